// File: rtl/kpn_fifo_reader.sv
// kpn_fifo_reader: consumer endpoint of a KPN channel FIFO (blocking read, 3-entry skid buffer).
// Optional statistics counters are enabled with `define KPN_READER_STATS_EN.
// ============================================================================
// Module   : kpn_fifo_reader
// Revision : 1.0
// ============================================================================
`default_nettype none

module kpn_fifo_reader #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              fifo_empty,
  output logic              fifo_rd,
  input  logic [DATA_W-1:0] fifo_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  tokens_read,
  output logic [CNT_W-1:0]  stall_cycles
);

  logic [DATA_W-1:0] buf_q [3];
  logic [1:0]        wr_ptr_q, wr_ptr_d;
  logic [1:0]        rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              inflight_q;

  logic [2:0]        w_occ;
  logic              w_cap;
  logic              w_pop;
  logic              w_space;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Space is reserved for the token already in flight, so out_ready never
  // reaches fifo_rd and the buffer cannot overflow.
  assign w_occ   = {1'b0, count_q} + {2'b00, inflight_q};
  assign w_space = (w_occ < 3'd3);
  assign fifo_rd = rst_n & en & ~fifo_empty & w_space;

  assign w_cap     = inflight_q;
  assign out_valid = (count_q != 2'd0);
  assign w_pop     = out_valid & out_ready;
  assign out_data  = out_valid ? buf_q[rd_ptr_q] : '0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_cap) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (w_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({w_cap, w_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= fifo_rd;
    end
  end

  // Storage needs no reset: out_data is masked whenever the buffer is empty.
  always_ff @(posedge clk) begin
    if (w_cap) buf_q[wr_ptr_q] <= fifo_data;
  end

`ifdef KPN_READER_STATS_EN
  logic [CNT_W-1:0] tokens_q;
  logic [CNT_W-1:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tokens_q <= '0;
      stall_q  <= '0;
    end else begin
      if (w_pop) tokens_q <= tokens_q + 1'b1;
      if (en && fifo_empty && w_space) stall_q <= stall_q + 1'b1;
    end
  end

  assign tokens_read  = tokens_q;
  assign stall_cycles = stall_q;
`else
  assign tokens_read  = '0;
  assign stall_cycles = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_kpn_fifo_reader.sv
// Scoreboard bench for kpn_fifo_reader: channel FIFO model, in-order token queue, stats model.
`default_nettype none

module tb_kpn_fifo_reader;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic              fifo_empty = 1'b1;
  logic              out_ready = 1'b0;
  logic              fifo_rd;
  logic              out_valid;
  logic [DATA_W-1:0] fifo_data = '0;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  tokens_read;
  logic [CNT_W-1:0]  stall_cycles;

  always #5 clk = ~clk;

  kpn_fifo_reader #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .fifo_empty   (fifo_empty),
    .fifo_rd      (fifo_rd),
    .fifo_data    (fifo_data),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .tokens_read  (tokens_read),
    .stall_cycles (stall_cycles)
  );

  // Channel contents, tokens owned by the reader (popped from the channel but
  // not yet delivered) and the cycle each was popped.
  logic [DATA_W-1:0] chan[$];
  logic [DATA_W-1:0] exp_d[$];
  int                exp_c[$];
  int                cyc = 0;
  logic              rd_s = 1'b0;
  logic [DATA_W-1:0] tok;

  int                vectors = 0;
  int                miscompares = 0;
  logic [CNT_W-1:0]  tokens_exp = '0;
  logic [CNT_W-1:0]  stall_exp = '0;
  logic              have_hold = 1'b0;
  logic [DATA_W-1:0] hold_data = '0;
  int                occ;
  logic              vis;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic logic [CNT_W-1:0] stat_exp(input logic [CNT_W-1:0] v);
`ifdef KPN_READER_STATS_EN
    return v;
`else
    return '0;
`endif
  endfunction

  // Channel FIFO: one-cycle read latency.
  always @(posedge clk) begin
    cyc++;
    if (rd_s && chan.size() != 0) begin
      tok = chan.pop_front();
      fifo_data <= tok;
      exp_d.push_back(tok);
      exp_c.push_back(cyc);
    end
  end

  // Monitor: a token becomes visible the cycle after it left the channel.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_fifo_rd", fifo_rd, 0);
      chk("rst_tokens_read", tokens_read, 0);
      chk("rst_stall_cycles", stall_cycles, 0);
      rd_s = 1'b0;
      have_hold = 1'b0;
    end else begin
      occ = exp_d.size();
      vis = (occ > 0) && (exp_c[0] < cyc);
      chk("occupancy_le3", occ <= 3, 1);
      chk("fifo_rd", fifo_rd, en && !fifo_empty && occ < 3);
      chk("out_valid", out_valid, vis);
      if (vis) chk("out_data", out_data, exp_d[0]);
      else     chk("out_data_zero", out_data, 0);
      if (have_hold && out_valid) chk("hold_stable", out_data, hold_data);
      chk("tokens_read", tokens_read, stat_exp(tokens_exp));
      chk("stall_cycles", stall_cycles, stat_exp(stall_exp));
      rd_s = fifo_rd;
      if (out_valid && out_ready) begin
        tokens_exp = tokens_exp + 1'b1;
        if (occ > 0) begin
          void'(exp_d.pop_front());
          void'(exp_c.pop_front());
        end
      end
      if (en && fifo_empty && occ < 3) stall_exp = stall_exp + 1'b1;
      have_hold = out_valid && !out_ready;
      hold_data = out_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    fifo_empty = (chan.size() == 0);
  endtask

  task automatic push(input logic [DATA_W-1:0] v);
    chan.push_back(v);
    fifo_empty = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    en = 1'b1;
    out_ready = 1'b1;
    while ((chan.size() != 0 || exp_d.size() != 0) && n < 200) begin
      step();
      n++;
    end
    step();
    chk("drain_within_bound", n < 200, 1);
  endtask

  task automatic do_reset(input int hold);
    rst_n = 1'b0;
    exp_d.delete();
    exp_c.delete();
    tokens_exp = '0;
    stall_exp = '0;
    have_hold = 1'b0;
    rd_s = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_out_data", out_data, 0);
    chk("async_rst_fifo_rd", fifo_rd, 0);
    chk("async_rst_tokens_read", tokens_read, 0);
    chk("async_rst_stall_cycles", stall_cycles, 0);
    repeat (hold) step();
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset with an empty channel: no reads, stall counting afterwards.
    en = 1'b1;
    out_ready = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (5) step();

    // Preloaded 10, 20, 30 with a ready consumer.
    push(16'd10); push(16'd20); push(16'd30);
    repeat (8) step();

    // Backpressure: five tokens, only three may be taken.
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) push(i[DATA_W-1:0]);
    repeat (8) step();
    chk("bp_chan_left", chan.size(), 2);
    out_ready = 1'b1;
    repeat (10) step();

    // Streaming with out_ready toggling every cycle.
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(3) != 0) push(DATA_W'($urandom));
      out_ready = ~out_ready;
      step();
    end
    // Fully random enable, readiness and arrivals.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(2) != 0 && chan.size() < 8) push(DATA_W'($urandom));
      out_ready = ($urandom_range(1) == 1);
      en = ($urandom_range(7) != 0);
      step();
    end
    drain();

    // Enable dropped right after the read of token 40.
    push(16'd40);
    step();
    en = 1'b0;
    push(16'd41);
    repeat (5) step();
    chk("en_off_41_waits", chan.size(), 1);
    en = 1'b1;
    repeat (4) step();
    drain();

    // Reset with two tokens buffered and one in flight; those are lost.
    out_ready = 1'b0;
    push(16'hA1); push(16'hA2); push(16'hA3);
    repeat (3) step();
    chk("pre_reset_owned", exp_d.size(), 3);
    do_reset(2);
    out_ready = 1'b1;
    repeat (10) step();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
